// File: rtl/care_pkg.sv
// Shared definitions for the pet care-action front-end: action indices,
// button indices, FSM state type and cursor wrap helpers.
package care_pkg;

  // Action / stat indices; bit i of the action bus targets stat nibble i.
  localparam int ACT_HUNGER    = 0;
  localparam int ACT_HAPPINESS = 1;
  localparam int ACT_HEALTH    = 2;
  localparam int ACT_HYGIENE   = 3;
  localparam int ACT_ENERGY    = 4;
  localparam int ACT_SOCIAL    = 5;
  localparam int NUM_ACTIONS   = 6;

  // Each stat is a 4-bit nibble on stats_in, hunger in the low nibble.
  localparam int STAT_W   = 4;
  localparam int CURSOR_W = 3;
  localparam int ACTION_W = 8;

  // Button lane indices into the packed raw/level/press vectors.
  localparam int BTN_NEXT = 0;
  localparam int BTN_BACK = 1;
  localparam int BTN_SEL  = 2;
  localparam int NUM_BTNS = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    COOLDOWN = 1'b1
  } state_t;

  // Cursor step forward, wrapping the last action back to the first.
  function automatic logic [CURSOR_W-1:0] cursor_inc(input logic [CURSOR_W-1:0] cur);
    if (cur >= CURSOR_W'(ACT_SOCIAL))
      return CURSOR_W'(ACT_HUNGER);
    else
      return cur + 1'b1;
  endfunction

  // Cursor step backward, wrapping the first action to the last.
  function automatic logic [CURSOR_W-1:0] cursor_dec(input logic [CURSOR_W-1:0] cur);
    if (cur == CURSOR_W'(ACT_HUNGER) || cur > CURSOR_W'(ACT_SOCIAL))
      return CURSOR_W'(ACT_SOCIAL);
    else
      return cur - 1'b1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Per-button conditioner: 2-FF synchronizer, stable-level counter and a
// single-cycle press pulse on each accepted rising change of the level.
// Releases are filtered identically but produce no pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Synchronize the raw pin, then accept a change only after it has held
  // for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/care_action_ctrl.sv
// Care-action front-end: three debounced buttons drive a 6-entry menu
// cursor and a select that emits a one-cycle one-hot pulse on the action
// bus, followed by a cooldown. Selects on an empty stat are refused.
// Optional feature macro: CARE_AUTOREPEAT_EN (held select re-fires after
// each cooldown).
module care_action_ctrl
  import care_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int COOLDOWN_CYCLES = 13500000,
  parameter int IDLE_TIMEOUT    = 270000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_back,
  input  logic        btn_sel,
  input  logic [23:0] stats_in,
  output logic [7:0]  actions,
  output logic [2:0]  cursor,
  output logic        busy,
  output logic        refused
);

  localparam int CD_W   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  // ---------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------
  logic [NUM_BTNS-1:0] w_btn_raw;
  logic [NUM_BTNS-1:0] w_btn_level;
  logic [NUM_BTNS-1:0] w_btn_press;

  assign w_btn_raw[BTN_NEXT] = btn_next;
  assign w_btn_raw[BTN_BACK] = btn_back;
  assign w_btn_raw[BTN_SEL]  = btn_sel;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(w_btn_raw[gi]),
        .level  (w_btn_level[gi]),
        .press  (w_btn_press[gi])
      );
    end
  endgenerate

  // Only the select level matters (for auto-repeat); the rest are idle taps.
  logic w_unused_levels;
  assign w_unused_levels = &{1'b0, w_btn_level};

  // Select wins over navigation in the same cycle; next+back cancel.
  logic w_sel_evt;
  logic w_next_evt;
  logic w_back_evt;
  logic w_any_evt;

  assign w_sel_evt  = w_btn_press[BTN_SEL];
  assign w_next_evt = w_btn_press[BTN_NEXT] & ~w_sel_evt & ~w_btn_press[BTN_BACK];
  assign w_back_evt = w_btn_press[BTN_BACK] & ~w_sel_evt & ~w_btn_press[BTN_NEXT];
  assign w_any_evt  = |w_btn_press;

  // ---------------------------------------------------------------------
  // Cursor and idle timeout
  // ---------------------------------------------------------------------
  logic [CURSOR_W-1:0] r_cursor;
  logic [IDLE_W-1:0]   r_idle_cnt;

  // Any button event restarts the idle timer; a full idle period with no
  // events returns the cursor home. The FSM is unaffected by the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cursor   <= '0;
      r_idle_cnt <= '0;
    end else if (w_any_evt) begin
      r_idle_cnt <= '0;
      if (w_next_evt)
        r_cursor <= cursor_inc(r_cursor);
      else if (w_back_evt)
        r_cursor <= cursor_dec(r_cursor);
    end else if (r_idle_cnt == IDLE_LAST) begin
      r_cursor   <= CURSOR_W'(ACT_HUNGER);
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Target stat lookup (cursor value before this cycle's update)
  // ---------------------------------------------------------------------
  logic [STAT_W-1:0] w_stat_nibble [NUM_ACTIONS];
  logic [STAT_W-1:0] w_target_stat;

  generate
    for (genvar gi = 0; gi < NUM_ACTIONS; gi++) begin : g_stat
      assign w_stat_nibble[gi] = stats_in[gi*STAT_W +: STAT_W];
    end
  endgenerate

  assign w_target_stat = (r_cursor < CURSOR_W'(NUM_ACTIONS)) ? w_stat_nibble[r_cursor] : '0;

  // ---------------------------------------------------------------------
  // Action FSM
  // ---------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_next;
  logic [CD_W-1:0]      r_cd_cnt;
  logic [CD_W-1:0]      w_cd_cnt_next;
  logic [ACTION_W-1:0]  r_actions;
  logic [ACTION_W-1:0]  w_actions_next;
  logic                 r_refused;
  logic                 w_refused_next;
  logic                 w_fire;
  logic                 w_cd_done;
  logic                 w_repeat;

`ifdef CARE_AUTOREPEAT_EN
  // Set for the first IDLE cycle after a cooldown; a still-held select
  // then behaves like a fresh press. A refusal leaves IDLE unchanged so
  // the flag is not set again and repeating stops until the next press.
  logic r_from_cd;

  // Remember that the previous cycle ended a cooldown.
  always_ff @(posedge clk) begin
    if (reset)
      r_from_cd <= 1'b0;
    else
      r_from_cd <= w_cd_done;
  end

  assign w_repeat = r_from_cd & w_btn_level[BTN_SEL];
`else
  assign w_repeat = 1'b0;
`endif

  assign w_fire    = w_sel_evt | w_repeat;
  assign w_cd_done = (r_state == COOLDOWN) && (r_cd_cnt == CD_LAST);

  // State, cooldown count and the registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cd_cnt  <= '0;
      r_actions <= '0;
      r_refused <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cd_cnt  <= w_cd_cnt_next;
      r_actions <= w_actions_next;
      r_refused <= w_refused_next;
    end
  end

  // Next-state logic: a fire in IDLE either launches the action pulse and
  // a cooldown that counts from the pulse cycle, or refuses an empty stat.
  always_comb begin
    w_state_next   = r_state;
    w_cd_cnt_next  = r_cd_cnt;
    w_actions_next = '0;
    w_refused_next = 1'b0;
    case (r_state)
      IDLE: begin
        w_cd_cnt_next = '0;
        if (w_fire) begin
          if (w_target_stat != '0) begin
            w_actions_next = ACTION_W'(1) << r_cursor;
            w_state_next   = COOLDOWN;
          end else begin
            w_refused_next = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        if (w_cd_done) begin
          w_state_next  = IDLE;
          w_cd_cnt_next = '0;
        end else begin
          w_cd_cnt_next = r_cd_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_cd_cnt_next = '0;
      end
    endcase
  end

  assign actions = r_actions;
  assign cursor  = r_cursor;
  assign busy    = (r_state == COOLDOWN);
  assign refused = r_refused;

endmodule

// File: tb/tb_care_action_ctrl.sv
// Directed bench for care_action_ctrl with short debounce/cooldown/idle
// timings. Expected latencies are hand-derived from input drive time:
// 2 sync cycles + 4 debounce cycles + 1 output register = 7 cycles.
// Define CARE_AUTOREPEAT_EN to exercise the auto-repeat build.
module tb_care_action_ctrl;

  localparam int DEB  = 4;
  localparam int CD   = 8;
  localparam int IDLE = 50;

`ifdef CARE_AUTOREPEAT_EN
  localparam int SEL_HOLD = 8;
`else
  localparam int SEL_HOLD = 20;
`endif

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        btn_next = 1'b0;
  logic        btn_back = 1'b0;
  logic        btn_sel  = 1'b0;
  logic [23:0] stats_in = 24'h333333;
  logic [7:0]  actions;
  logic [2:0]  cursor;
  logic        busy;
  logic        refused;

  care_action_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .COOLDOWN_CYCLES(CD),
    .IDLE_TIMEOUT   (IDLE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_next(btn_next),
    .btn_back(btn_back),
    .btn_sel (btn_sel),
    .stats_in(stats_in),
    .actions (actions),
    .cursor  (cursor),
    .busy    (busy),
    .refused (refused)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor sampled on the falling edge.
  int         act_total  = 0;
  int         ref_total  = 0;
  int         busy_total = 0;
  int         act_cyc    = -1;
  int         ref_cyc    = -1;
  int         viol       = 0;
  logic [7:0] last_act   = 8'h00;
  logic [7:0] prev_act   = 8'h00;

  always @(negedge clk) begin
    if (actions != 8'h00) begin
      act_total++;
      act_cyc  = cyc;
      last_act = actions;
      if (prev_act != 8'h00 || $countones(actions) != 1 || actions[7:6] != 2'b00)
        viol++;
    end
    if (refused) begin
      ref_total++;
      ref_cyc = cyc;
    end
    if (busy) busy_total++;
    prev_act = actions;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
    $display("check %-20s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic n, input logic b, input logic s);
    btn_next = n;
    btn_back = b;
    btn_sel  = s;
    tick(8);
    btn_next = 1'b0;
    btn_back = 1'b0;
    btn_sel  = 1'b0;
    tick(12);
  endtask

  int a0, r0, b0, c0;

  initial begin
    // Reset state
    tick(3);
    check("rst_actions", 32'(actions), 32'h0);
    check("rst_cursor",  32'(cursor),  32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_refused", 32'(refused), 32'h0);
    reset = 1'b0;
    tick(2);

    // 1: bouncy next gives one step; back wraps 0 -> 5
    for (int i = 0; i < 10; i++) begin
      btn_next = ((i / 2) % 2) == 0;
      tick(1);
    end
    btn_next = 1'b1;
    tick(8);
    btn_next = 1'b0;
    tick(12);
    check("bouncy_next_cursor", 32'(cursor), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    check("back_to_0", 32'(cursor), 32'd0);
    press(1'b0, 1'b1, 1'b0);
    check("back_wrap_5", 32'(cursor), 32'd5);
    press(1'b1, 1'b0, 1'b0);
    check("next_wrap_0", 32'(cursor), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("cursor_2", 32'(cursor), 32'd2);

    // 2: held select at cursor 2 -> single 8'h04 pulse, 8 busy cycles
    a0 = act_total; r0 = ref_total; b0 = busy_total; c0 = cyc;
    btn_sel = 1'b1;
    tick(SEL_HOLD);
    btn_sel = 1'b0;
    tick(15);
    check("t2_act_count",   32'(act_total - a0),  32'd1);
    check("t2_act_value",   32'(last_act),        32'h04);
    check("t2_act_latency", 32'(act_cyc - c0),    32'd7);
    check("t2_busy_cycles", 32'(busy_total - b0), 32'd8);
    check("t2_no_refuse",   32'(ref_total - r0),  32'd0);

    // 3: empty energy stat at cursor 4 -> refused, then a press fires
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("cursor_4", 32'(cursor), 32'd4);
    stats_in = 24'h303333;
    a0 = act_total; r0 = ref_total; b0 = busy_total; c0 = cyc;
    btn_sel = 1'b1;
    tick(8);
    btn_sel = 1'b0;
    tick(12);
    check("t3_ref_count",   32'(ref_total - r0),  32'd1);
    check("t3_ref_latency", 32'(ref_cyc - c0),    32'd7);
    check("t3_no_action",   32'(act_total - a0),  32'd0);
    check("t3_no_busy",     32'(busy_total - b0), 32'd0);
    stats_in = 24'h333333;
    a0 = act_total;
    press(1'b0, 1'b0, 1'b1);
    check("t3_refire_count", 32'(act_total - a0), 32'd1);
    check("t3_refire_value", 32'(last_act),       32'h10);

    // 4: sel evt in the last cooldown cycle is ignored; next still moves
    a0 = act_total; r0 = ref_total; c0 = cyc;
    btn_sel = 1'b1;
    tick(1);
    btn_next = 1'b1;
    tick(3);
    btn_sel = 1'b0;
    tick(1);
    btn_next = 1'b0;
    tick(3);
    btn_sel = 1'b1;
    tick(4);
    btn_sel = 1'b0;
    tick(20);
`ifdef CARE_AUTOREPEAT_EN
    check("t4_act_count", 32'(act_total - a0), 32'd2);
    check("t4_last_act",  32'(last_act),       32'h20);
`else
    check("t4_act_count", 32'(act_total - a0), 32'd1);
    check("t4_last_act",  32'(last_act),       32'h10);
`endif
    check("t4_no_refuse", 32'(ref_total - r0), 32'd0);
    check("t4_cursor",    32'(cursor),         32'd5);

    // 5: sel + next together fire at cursor 1; next + back cancel
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("cursor_1", 32'(cursor), 32'd1);
    a0 = act_total;
    press(1'b1, 1'b0, 1'b1);
    check("t5_act_count", 32'(act_total - a0), 32'd1);
    check("t5_act_value", 32'(last_act),       32'h02);
    check("t5_cursor",    32'(cursor),         32'd1);
    press(1'b1, 1'b1, 1'b0);
    check("t5_cancel",    32'(cursor),         32'd1);

    // 6a: idle timeout returns cursor 3 to 0 fifty cycles after the last evt
    press(1'b1, 1'b0, 1'b0);
    c0 = cyc;
    btn_next = 1'b1;
    tick(8);
    btn_next = 1'b0;
    tick(47);
    check("t6_before_timeout", 32'(cursor), 32'd3);
    tick(3);
    check("t6_after_timeout",  32'(cursor), 32'd0);

    // 6b: reset one cycle after a pulse clears busy and cursor
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    a0 = act_total; c0 = cyc;
    btn_sel = 1'b1;
    tick(5);
    btn_sel = 1'b0;
    tick(3);
    check("t6_pre_rst_busy",  32'(busy),             32'd1);
    check("t6_pre_rst_pulse", 32'(act_total - a0),   32'd1);
    reset = 1'b1;
    tick(1);
    check("t6_rst_busy",    32'(busy),    32'd0);
    check("t6_rst_cursor",  32'(cursor),  32'd0);
    check("t6_rst_actions", 32'(actions), 32'd0);
    reset = 1'b0;
    tick(12);

`ifdef CARE_AUTOREPEAT_EN
    // 6c: held select repeats every CD+1 cycles
    a0 = act_total; c0 = cyc;
    btn_sel = 1'b1;
    tick(8);
    check("t6_rep_first", 32'(act_cyc - c0), 32'd7);
    tick(22);
    btn_sel = 1'b0;
    tick(20);
    check("t6_rep_count", 32'(act_total - a0), 32'd4);
    check("t6_rep_last",  32'(act_cyc - c0),   32'd34);
`endif

    check("pulse_rules", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
